// File: rtl/uart_rx.sv
// UART receiver: 2-flop input sync, PRESCALE-times oversampling, 3-sample majority vote,
// optional even/odd parity, one-cycle result strobes.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low
// START  | confirming start bit (majority 1 = glitch, back to IDLE)
// DATA   | collecting DATA_WIDTH bits, LSB first
// PARITY | checking parity bit against latched PAR_TYP
// STOP   | checking stop bit, issuing strobes on its last edge
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err,
    output logic                  rx_busy
);

    localparam int CW = $clog2(PRESCALE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] EDGE_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] SMP_0     = CW'(PRESCALE / 2 - 1);
    localparam logic [CW-1:0] SMP_1     = CW'(PRESCALE / 2);
    localparam logic [CW-1:0] SMP_2     = CW'(PRESCALE / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                  state;
    logic                    rx_meta;
    logic                    rx_s;
    logic [CW-1:0]           edge_cnt;
    logic [BW-1:0]           bit_cnt;
    logic                    smp0;
    logic                    smp1;
    logic                    bit_val;
    logic                    maj;
    logic [DATA_WIDTH-1:0]   shreg;
    logic                    par_en_l;
    logic                    par_typ_l;
    logic                    par_fail;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX_IN;
            rx_s    <= rx_meta;
        end
    end

    // third sample is the live rx_s on the SMP_2 edge
    assign maj = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            smp0       <= 1'b1;
            smp1       <= 1'b1;
            bit_val    <= 1'b1;
            shreg      <= '0;
            par_en_l   <= 1'b0;
            par_typ_l  <= 1'b0;
            par_fail   <= 1'b0;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;

            if (state != IDLE) begin
                edge_cnt <= (edge_cnt == EDGE_LAST) ? '0 : edge_cnt + 1'b1;
                if (edge_cnt == SMP_0) smp0    <= rx_s;
                if (edge_cnt == SMP_1) smp1    <= rx_s;
                if (edge_cnt == SMP_2) bit_val <= maj;
            end

            case (state)
                IDLE: begin
                    // the detect edge is edge 0 of the start bit
                    if (!rx_s) begin
                        par_en_l  <= PAR_EN;
                        par_typ_l <= PAR_TYP;
                        par_fail  <= 1'b0;
                        edge_cnt  <= CW'(1);
                        rx_busy   <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (edge_cnt == EDGE_LAST) begin
                        if (!bit_val) begin
                            bit_cnt <= '0;
                            state   <= DATA;
                        end else begin
                            rx_busy <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (edge_cnt == EDGE_LAST) begin
                        shreg[bit_cnt] <= bit_val;
                        if (bit_cnt == BIT_LAST) begin
                            state <= par_en_l ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (edge_cnt == EDGE_LAST) begin
                        if (bit_val != ((^shreg) ^ par_typ_l)) par_fail <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (edge_cnt == EDGE_LAST) begin
                        Par_Err <= par_fail;
                        Stp_Err <= ~bit_val;
                        if (!par_fail && bit_val) begin
                            Data_Valid <= 1'b1;
                            P_DATA     <= shreg;
                        end
                        rx_busy <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    rx_busy <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized frames against a frame-level reference model of uart_rx.
module tb_uart_rx;

    localparam int DW = 8;
    localparam int P  = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          RX_IN = 1'b1;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          Par_Err;
    logic          Stp_Err;
    logic          rx_busy;

    uart_rx #(.DATA_WIDTH(DW), .PRESCALE(P)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .P_DATA(P_DATA), .Data_Valid(Data_Valid), .Par_Err(Par_Err),
        .Stp_Err(Stp_Err), .rx_busy(rx_busy)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic          dv;
        logic          pe;
        logic          se;
        int            cyc;
        int            rise;
        int            idle;
    } ev_t;

    typedef struct {
        logic          dv;
        logic          pe;
        logic          se;
        int            nbits;
    } exp_t;

    ev_t           evq[$];
    exp_t          expq[$];
    logic [DW-1:0] model_pdata = '0;

    int   cyc = 0;
    int   last_rise = 0;
    int   idle_cnt = 0;
    logic busy_d = 1'b0;

    // strobe monitor, sampled on the inactive edge
    always @(negedge CLK) begin
        ev_t e;
        cyc    <= cyc + 1;
        busy_d <= rx_busy;
        if (rx_busy && !busy_d) last_rise <= cyc;
        if (Data_Valid || Par_Err || Stp_Err) begin
            e.data = P_DATA; e.dv = Data_Valid; e.pe = Par_Err; e.se = Stp_Err;
            e.cyc = cyc; e.rise = last_rise; e.idle = idle_cnt;
            evq.push_back(e);
        end
        if (!rx_busy) idle_cnt <= idle_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one frame bit-serially and records the outcome the protocol rules predict.
    task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic ptyp,
                              input logic flip_par, input logic stop_bit,
                              input int glitch_bit, input int glitch_pos, input logic scramble);
        logic bits[DW+3];
        int   n;
        exp_t x;
        n = 0;
        bits[n++] = 1'b0;
        for (int k = 0; k < DW; k++) bits[n++] = d[k];
        if (pen) bits[n++] = (^d) ^ ptyp ^ flip_par;
        bits[n++] = stop_bit;
        PAR_EN  = pen;
        PAR_TYP = ptyp;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < P; j++) begin
                @(negedge CLK);
                RX_IN = (i == glitch_bit && j == glitch_pos) ? ~bits[i] : bits[i];
                if (scramble && i == 1 && j == 0) begin
                    PAR_EN  = 1'($urandom);
                    PAR_TYP = 1'($urandom);
                end
            end
        end
        x.pe = pen && flip_par;
        x.se = !stop_bit;
        x.dv = !x.pe && !x.se;
        x.nbits = n;
        if (x.dv) model_pdata = d;
        expq.push_back(x);
    endtask

    task automatic line_idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK);
            RX_IN = 1'b1;
        end
    endtask

    task automatic check_frame(input string tag);
        ev_t  e;
        exp_t x;
        line_idle(6);
        chk({tag, "_strobes"}, evq.size(), 1);
        if (evq.size() > 0 && expq.size() > 0) begin
            e = evq.pop_front();
            x = expq.pop_front();
            chk({tag, "_dv"}, e.dv, x.dv);
            chk({tag, "_par_err"}, e.pe, x.pe);
            chk({tag, "_stp_err"}, e.se, x.se);
            chk({tag, "_p_data"}, e.data, model_pdata);
            chk({tag, "_latency"}, e.cyc - e.rise, x.nbits * P - 1);
        end
        chk({tag, "_busy_idle"}, rx_busy, 1'b0);
        evq.delete();
        expq.delete();
    endtask

    initial begin
        ev_t e1;
        ev_t e2;
        int  prev_rise;

        // reset state
        repeat (3) @(negedge CLK);
        chk("rst_p_data", P_DATA, 0);
        chk("rst_dv", Data_Valid, 0);
        chk("rst_par_err", Par_Err, 0);
        chk("rst_stp_err", Stp_Err, 0);
        chk("rst_busy", rx_busy, 0);
        RST = 1'b1;
        line_idle(4);

        // basic frame, no parity
        send_frame(8'hA5, 0, 0, 0, 1, -1, 0, 0);
        check_frame("a5");

        // parity: even ok, even wrong, odd ok
        send_frame(8'h3C, 1, 0, 0, 1, -1, 0, 0);
        check_frame("even_ok");
        send_frame(8'h3C, 1, 0, 1, 1, -1, 0, 0);
        check_frame("even_bad");
        send_frame(8'h3C, 1, 1, 0, 1, -1, 0, 0);
        check_frame("odd_ok");

        // stop errors, alone and with parity error
        send_frame(8'h55, 0, 0, 0, 0, -1, 0, 0);
        check_frame("stop_bad");
        send_frame(8'h55, 1, 0, 1, 0, -1, 0, 0);
        check_frame("par_stop_bad");

        // start-bit glitch rejected
        prev_rise = last_rise;
        @(negedge CLK); RX_IN = 1'b0;
        @(negedge CLK); RX_IN = 1'b0;
        line_idle(14);
        chk("glitch_busy_seen", (last_rise != prev_rise), 1);
        chk("glitch_no_strobe", evq.size(), 0);
        chk("glitch_busy_idle", rx_busy, 0);

        // single flipped mid-sample inside a data bit
        send_frame(8'h5A, 0, 0, 0, 1, 3, P / 2, 0);
        check_frame("maj_flip");

        // back-to-back frames, no idle gap
        send_frame(8'h01, 0, 0, 0, 1, -1, 0, 0);
        send_frame(8'hFF, 0, 0, 0, 1, -1, 0, 0);
        line_idle(6);
        chk("b2b_strobes", evq.size(), 2);
        if (evq.size() == 2) begin
            e1 = evq.pop_front();
            e2 = evq.pop_front();
            chk("b2b_first_data", e1.data, 8'h01);
            chk("b2b_first_dv", e1.dv, 1);
            chk("b2b_second_data", e2.data, 8'hFF);
            chk("b2b_second_dv", e2.dv, 1);
            chk("b2b_spacing", e2.cyc - e1.cyc, 10 * P);
            chk("b2b_idle_cycles", e2.idle - e1.idle, 1);
        end
        evq.delete();
        expq.delete();

        // reset in the middle of a data bit
        for (int j = 0; j < P; j++) begin @(negedge CLK); RX_IN = 1'b0; end
        for (int j = 0; j < 2 * P + P / 2; j++) begin @(negedge CLK); RX_IN = j[3]; end
        #2 RST = 1'b0;
        #1;
        chk("midrst_p_data", P_DATA, 0);
        chk("midrst_dv", Data_Valid, 0);
        chk("midrst_busy", rx_busy, 0);
        RX_IN = 1'b1;
        model_pdata = '0;
        line_idle(3);
        RST = 1'b1;
        line_idle(P * 12);
        chk("midrst_no_strobe", evq.size(), 0);
        send_frame(8'h7E, 0, 0, 0, 1, -1, 0, 0);
        check_frame("after_rst");

        // randomized frames with mid-frame config changes and single-sample glitches
        for (int r = 0; r < 24; r++) begin
            logic [DW-1:0] d;
            logic          pen, ptyp, fp, sb;
            int            gb, gp;
            d    = DW'($urandom);
            pen  = 1'($urandom);
            ptyp = 1'($urandom);
            fp   = ($urandom_range(0, 3) == 0);
            sb   = ($urandom_range(0, 4) != 0);
            gb   = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, DW));
            gp   = int'($urandom_range(P / 2 - 1, P / 2 + 1));
            send_frame(d, pen, ptyp, fp, sb, gb, gp, 1);
            check_frame("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
